// File: rtl/spi_shift_reg_if.sv
// SPI shift register bus: transfer control, parallel data and serial pins.
// The master drives requests and MISO; the slave (the shift register)
// returns MOSI, the received word and transfer status.
interface spi_shift_reg_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] din;
   logic             bit_en;
   logic             abort;
   logic             serial_in;
   logic             serial_out;
   logic [WIDTH-1:0] dout;
   logic             busy;
   logic             done;

   modport master (
      output start, din, bit_en, abort, serial_in,
      input  serial_out, dout, busy, done
   );

   modport slave (
      input  start, din, bit_en, abort, serial_in,
      output serial_out, dout, busy, done
   );
endinterface

// File: rtl/spi_shift_reg.sv
// SPI data shift register with a three-state transfer FSM (IDLE/SHIFT/DONE).
// One bit_en strobe moves one bit: the output end drives MOSI while MISO
// enters at the opposite end, so after WIDTH strobes the register holds the
// received word. The output end is selected by LSB_FIRST.
module spi_shift_reg #(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b0
) (
   input logic            clk,
   input logic            reset,
   spi_shift_reg_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [1:0]       state_d, state_q;
   logic [WIDTH-1:0] sr_d, sr_q;
   logic [WIDTH-1:0] dout_d, dout_q;
   logic [CW-1:0]    cnt_d, cnt_q;
   logic [WIDTH-1:0] sr_shifted_s;

   // Move the register one place toward its output end, feeding b in behind.
   function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v,
                                                  input logic b);
      if (LSB_FIRST) begin
         return {b, v[WIDTH-1:1]};
      end else begin
         return {v[WIDTH-2:0], b};
      end
   endfunction

   assign sr_shifted_s = shift_one(sr_q, bus.serial_in);

   // Next-state, shift register, bit counter and received-word logic.
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      case (state_q)
         ST_IDLE: begin
            // bit_en and abort are meaningless here; only start matters
            if (bus.start) begin
               sr_d    = bus.din;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            // abort has priority over a coincident strobe: nothing shifts
            if (bus.abort) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else if (bus.bit_en) begin
               sr_d  = sr_shifted_s;
               cnt_d = cnt_q + CNT_ONE;
               if (cnt_q == CNT_LAST) begin
                  dout_d  = sr_shifted_s;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_SHIFT;
               end
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_DONE: begin
            // single-cycle completion marker; start/bit_en/abort are ignored
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
         default: begin
            sr_d    = '0;
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
      end
   end

   // MOSI follows the output end directly so the first bit is ready right after start.
   assign bus.serial_out = LSB_FIRST ? sr_q[0] : sr_q[WIDTH-1];
   assign bus.dout       = dout_q;
   assign bus.busy       = (state_q == ST_SHIFT) || (state_q == ST_DONE);
   assign bus.done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_spi_shift_reg.sv
// Testbench for spi_shift_reg: an 8-bit MSB-first and an 8-bit LSB-first
// instance share one stimulus stream; a 16-bit MSB-first instance runs with
// MOSI looped back to MISO. Expected received words go into queues that a
// monitor pops on every done pulse.
module tb_spi_shift_reg;

   logic clk = 1'b0;
   logic reset;

   logic       start8, bit_en8, abort8, sin8;
   logic [7:0] din8;
   logic        start16, bit_en16, abort16;
   logic [15:0] din16;

   logic [7:0]  q_m[$];
   logic [7:0]  q_l[$];
   logic [15:0] q_w[$];

   logic [7:0] last_m, last_l;   // expected dout of each 8-bit instance
   logic       idle_so_m, idle_so_l;

   int n_checks = 0;
   int n_errors = 0;

   spi_shift_reg_if #(.WIDTH(8))  if_m ();
   spi_shift_reg_if #(.WIDTH(8))  if_l ();
   spi_shift_reg_if #(.WIDTH(16)) if_w ();

   assign if_m.start = start8;  assign if_m.din = din8;  assign if_m.bit_en = bit_en8;
   assign if_m.abort = abort8;  assign if_m.serial_in = sin8;
   assign if_l.start = start8;  assign if_l.din = din8;  assign if_l.bit_en = bit_en8;
   assign if_l.abort = abort8;  assign if_l.serial_in = sin8;
   assign if_w.start = start16; assign if_w.din = din16; assign if_w.bit_en = bit_en16;
   assign if_w.abort = abort16; assign if_w.serial_in = if_w.serial_out;

   spi_shift_reg #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (.clk(clk), .reset(reset), .bus(if_m));
   spi_shift_reg #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (.clk(clk), .reset(reset), .bus(if_l));
   spi_shift_reg #(.WIDTH(16), .LSB_FIRST(1'b0)) u_w16 (.clk(clk), .reset(reset), .bus(if_w));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Received word from the arrival order of MISO bits: MSB-first puts the
   // first bit at the top, LSB-first puts it at bit 0.
   function automatic logic [7:0] rx_word(input logic [7:0] rseq, input bit lsb);
      logic [7:0] w = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (lsb) w[i] = rseq[i];
         else     w[7-i] = rseq[i];
      end
      return w;
   endfunction

   // Monitor: every done pulse must match the oldest expected word.
   always @(negedge clk) begin
      if (reset) begin
         if (if_m.done) begin
            if (q_m.size() == 0) chk("unexpected_done_msb", if_m.done, 0);
            else chk("dout_msb", if_m.dout, q_m.pop_front());
         end
         if (if_l.done) begin
            if (q_l.size() == 0) chk("unexpected_done_lsb", if_l.done, 0);
            else chk("dout_lsb", if_l.dout, q_l.pop_front());
         end
         if (if_w.done) begin
            if (q_w.size() == 0) chk("unexpected_done_w16", if_w.done, 0);
            else chk("dout_w16", if_w.dout, q_w.pop_front());
         end
      end
   end

   // One 8-bit transfer; rseq[i] is the i-th MISO bit. abort_at/glitch_at
   // select the strobe index before which an abort or stray start occurs.
   task automatic run8(input logic [7:0] d, input logic [7:0] rseq, input int abort_at,
                       input bit abort_bit, input int glitch_at, input int max_gap);
      logic [7:0] em, el;
      em = rx_word(rseq, 1'b0);
      el = rx_word(rseq, 1'b1);
      start8 = 1'b1; din8 = d;
      tick();
      start8 = 1'b0; din8 = 8'($urandom);
      chk("busy_after_start", {if_m.busy, if_l.busy}, 2'b11);
      for (int i = 0; i < 8; i++) begin
         int gap;
         gap = $urandom_range(max_gap, 0);
         for (int g = 0; g < gap; g++) tick();
         if (i == glitch_at) begin
            start8 = 1'b1; din8 = ~d;
            tick();
            start8 = 1'b0;
         end
         chk("tx_msb", if_m.serial_out, d[7-i]);
         chk("tx_lsb", if_l.serial_out, d[i]);
         if (i == abort_at) begin
            abort8 = 1'b1; bit_en8 = abort_bit; sin8 = ~rseq[i];
            tick();
            abort8 = 1'b0; bit_en8 = 1'b0;
            chk("abort_busy", {if_m.busy, if_l.busy}, 2'b00);
            chk("abort_done", {if_m.done, if_l.done}, 2'b00);
            chk("abort_noshift_msb", if_m.serial_out, d[7-i]);
            chk("abort_noshift_lsb", if_l.serial_out, d[i]);
            chk("abort_dout_msb", if_m.dout, last_m);
            chk("abort_dout_lsb", if_l.dout, last_l);
            idle_so_m = d[7-i];
            idle_so_l = d[i];
            tick();
            chk("abort_no_done_later", {if_m.done, if_l.done}, 2'b00);
            return;
         end
         sin8 = rseq[i]; bit_en8 = 1'b1;
         if (i == 7) begin
            q_m.push_back(em); q_l.push_back(el);
            last_m = em; last_l = el;
         end
         tick();
         bit_en8 = 1'b0;
      end
      chk("done_pulse", {if_m.done, if_l.done}, 2'b11);
      chk("busy_in_done", {if_m.busy, if_l.busy}, 2'b11);
      // requests during DONE must all be ignored
      start8 = 1'b1; din8 = ~d; bit_en8 = 1'b1; abort8 = 1'b1; sin8 = 1'b1;
      tick();
      start8 = 1'b0; bit_en8 = 1'b0; abort8 = 1'b0;
      chk("busy_dropped", {if_m.busy, if_l.busy}, 2'b00);
      chk("done_single_cycle", {if_m.done, if_l.done}, 2'b00);
      chk("dout_hold_msb", if_m.dout, em);
      chk("dout_hold_lsb", if_l.dout, el);
      idle_so_m = rseq[0];
      idle_so_l = rseq[0];
      chk("idle_so_msb", if_m.serial_out, idle_so_m);
      chk("idle_so_lsb", if_l.serial_out, idle_so_l);
   endtask

   // 16-bit loopback transfer with random gaps; the word must come back intact.
   task automatic run16(input logic [15:0] d);
      start16 = 1'b1; din16 = d;
      tick();
      start16 = 1'b0; din16 = 16'($urandom);
      for (int i = 0; i < 16; i++) begin
         int gap;
         gap = $urandom_range(7, 0);
         for (int g = 0; g < gap; g++) tick();
         chk("tx_w16", if_w.serial_out, d[15-i]);
         bit_en16 = 1'b1;
         if (i == 15) q_w.push_back(d);
         tick();
         bit_en16 = 1'b0;
      end
      chk("done_w16", if_w.done, 1'b1);
      tick();
      chk("idle_w16", {if_w.busy, if_w.done}, 2'b00);
   endtask

   initial begin
      reset = 1'b0;
      start8 = 1'b0; bit_en8 = 1'b0; abort8 = 1'b0; sin8 = 1'b0; din8 = 8'h00;
      start16 = 1'b0; bit_en16 = 1'b0; abort16 = 1'b0; din16 = 16'h0000;
      last_m = 8'h00; last_l = 8'h00; idle_so_m = 1'b0; idle_so_l = 1'b0;
      tick(); tick();
      chk("rst_msb", {if_m.serial_out, if_m.dout, if_m.busy, if_m.done}, 11'h000);
      chk("rst_lsb", {if_l.serial_out, if_l.dout, if_l.busy, if_l.done}, 11'h000);
      chk("rst_w16", {if_w.serial_out, if_w.dout, if_w.busy, if_w.done}, 19'h00000);
      reset = 1'b1;
      tick();

      // MISO 0,0,1,1,1,1,0,0 with din 0x0F: received 0x3C in both bit orders
      run8(8'h0F, 8'h3C, -1, 1'b0, -1, 0);
      // abort after 3 strobes, then abort coinciding with a strobe
      run8(8'hA5, 8'($urandom), 3, 1'b0, -1, 2);
      run8(8'h96, 8'($urandom), 4, 1'b1, -1, 1);
      // stray start (0x55) two cycles into a 0xAA transfer
      run8(8'hAA, 8'($urandom), -1, 1'b0, 2, 1);

      // bit_en/abort while idle change nothing
      for (int k = 0; k < 4; k++) begin
         bit_en8 = k[0]; abort8 = k[1]; sin8 = ~sin8;
         tick();
      end
      bit_en8 = 1'b0; abort8 = 1'b0;
      chk("idle_ignore_busy", {if_m.busy, if_l.busy}, 2'b00);
      chk("idle_ignore_so_msb", if_m.serial_out, idle_so_m);
      chk("idle_ignore_so_lsb", if_l.serial_out, idle_so_l);
      chk("idle_ignore_dout", {if_m.dout, if_l.dout}, {last_m, last_l});

      // reset in the middle of a transfer after 5 strobes
      start8 = 1'b1; din8 = 8'h5A;
      tick();
      start8 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bit_en8 = 1'b1; sin8 = 1'($urandom);
         tick();
         bit_en8 = 1'b0;
      end
      reset = 1'b0;
      #2;
      chk("async_rst_msb", {if_m.serial_out, if_m.dout, if_m.busy, if_m.done}, 11'h000);
      chk("async_rst_lsb", {if_l.serial_out, if_l.dout, if_l.busy, if_l.done}, 11'h000);
      tick(); tick();
      reset = 1'b1;
      last_m = 8'h00; last_l = 8'h00;
      tick();
      chk("post_rst_idle", {if_m.busy, if_m.done, if_l.busy, if_l.done}, 4'h0);
      run8(8'hC3, 8'($urandom), -1, 1'b0, -1, 2);

      // randomized transfers, some with aborts or stray starts
      for (int n = 0; n < 20; n++) begin
         int ab, gl;
         ab = ($urandom_range(3, 0) == 0) ? int'($urandom_range(7, 0)) : -1;
         gl = ($urandom_range(3, 0) == 0) ? int'($urandom_range(7, 0)) : -1;
         run8(8'($urandom), 8'($urandom), ab, 1'($urandom), gl, 3);
      end

      run16(16'hBEEF);
      for (int n = 0; n < 3; n++) run16(16'($urandom));

      tick(); tick();
      chk("queues_drained", q_m.size() + q_l.size() + q_w.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
